// File: rtl/rob_pkg.sv
// Shared types for the multi-channel reorder buffer: commit-kind encoding and entry payload.
package rob_pkg;

    localparam int unsigned ROB_TYPE_W = 2;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DEST_W     = 5;

    typedef enum logic [ROB_TYPE_W-1:0] {
        ROB_REG    = 2'b00,
        ROB_BRANCH = 2'b01,
        ROB_STORE  = 2'b10,
        ROB_HALT   = 2'b11
    } rob_type_e;

    typedef struct packed {
        rob_type_e           kind;
        logic                jump;
        logic [DATA_W-1:0]   value;
        logic [DEST_W-1:0]   dest;
        logic [DATA_W-1:0]   miss_addr;
        logic [DATA_W-1:0]   instr_addr;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_mc_if.sv
// Bundle of allocation, writeback, operand-lookup and commit signals around the reorder buffer.
interface reorder_buffer_mc_if
    import rob_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = 4,
    parameter int unsigned WB_PORTS  = 2
);

    logic                          clear;
    logic [DATA_W-1:0]             newPc;
    logic [WB_PORTS-1:0]           wbValid;
    logic [WB_PORTS*ROB_WIDTH-1:0] wbRobIndex;
    logic [WB_PORTS*DATA_W-1:0]    wbValue;
    logic                          addValid;
    logic [ROB_TYPE_W-1:0]         addType;
    logic                          addReady;
    logic                          addJump;
    logic [DATA_W-1:0]             addValue;
    logic [DATA_W-1:0]             addAddr;
    logic [DATA_W-1:0]             addInstrAddr;
    logic [DEST_W-1:0]             addDest;
    logic                          full;
    logic [ROB_WIDTH-1:0]          next;
    logic [ROB_WIDTH-1:0]          rs1Dep;
    logic [ROB_WIDTH-1:0]          rs2Dep;
    logic                          rs1Ready;
    logic                          rs2Ready;
    logic [DATA_W-1:0]             rs1Value;
    logic [DATA_W-1:0]             rs2Value;
    logic                          regUpdateValid;
    logic [DEST_W-1:0]             regUpdateDest;
    logic [DATA_W-1:0]             regValue;
    logic [ROB_WIDTH-1:0]          regUpdateRobId;
    logic                          predictUpdValid;
    logic [DATA_W-1:0]             updInstrAddr;
    logic                          jumpResult;
    logic                          storeCommitValid;
    logic [ROB_WIDTH-1:0]          storeCommitRobId;
    logic [ROB_WIDTH-1:0]          robBeginId;
    logic                          beginValid;
    logic                          halted;

    modport slave (
        input  wbValid, wbRobIndex, wbValue,
        input  addValid, addType, addReady, addJump, addValue, addAddr, addInstrAddr, addDest,
        input  rs1Dep, rs2Dep,
        output clear, newPc, full, next, rs1Ready, rs2Ready, rs1Value, rs2Value,
        output regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        output predictUpdValid, updInstrAddr, jumpResult,
        output storeCommitValid, storeCommitRobId, robBeginId, beginValid, halted
    );

    modport master (
        output wbValid, wbRobIndex, wbValue,
        output addValid, addType, addReady, addJump, addValue, addAddr, addInstrAddr, addDest,
        output rs1Dep, rs2Dep,
        input  clear, newPc, full, next, rs1Ready, rs2Ready, rs1Value, rs2Value,
        input  regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        input  predictUpdValid, updInstrAddr, jumpResult,
        input  storeCommitValid, storeCommitRobId, robBeginId, beginValid, halted
    );

endinterface

// File: rtl/rob_operand_lookup.sv
// Combinational operand lookup for one source: stored entry state, overridden by same-cycle writeback.
module rob_operand_lookup
    import rob_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = 4,
    parameter int unsigned ROB_SIZE  = 2 ** ROB_WIDTH,
    parameter int unsigned WB_PORTS  = 2
) (
    input  logic [ROB_WIDTH-1:0]              dep,
    input  logic [ROB_SIZE-1:0]               entry_valid,
    input  logic [ROB_SIZE-1:0]               entry_ready,
    input  logic [ROB_SIZE-1:0][DATA_W-1:0]   entry_value,
    input  logic [WB_PORTS-1:0]               wb_valid,
    input  logic [WB_PORTS*ROB_WIDTH-1:0]     wb_index,
    input  logic [WB_PORTS*DATA_W-1:0]        wb_value,
    output logic                              ready_c,
    output logic [DATA_W-1:0]                 value_c
);

    // Ascending scan so the highest matching channel has the last word.
    always_comb begin
        ready_c = entry_valid[dep] & entry_ready[dep];
        value_c = entry_value[dep];
        for (int k = 0; k < WB_PORTS; k++) begin
            if (wb_valid[k] && (wb_index[k*ROB_WIDTH +: ROB_WIDTH] == dep)) begin
                ready_c = 1'b1;
                value_c = wb_value[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_mc.sv
// Circular in-order commit queue with several writeback channels, branch flush, store release and halt.
module reorder_buffer_mc
    import rob_pkg::*;
#(
    parameter int unsigned ROB_WIDTH   = 4,
    parameter int unsigned ROB_SIZE    = 2 ** ROB_WIDTH,
    parameter int unsigned WB_PORTS    = 2,
    parameter int unsigned FULL_MARGIN = 3
) (
    input logic                clockIn,
    input logic                resetIn,
    reorder_buffer_mc_if.slave bus
);

    localparam int unsigned CNT_W = ROB_WIDTH + 1;

    logic [ROB_WIDTH-1:0]             head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [ROB_SIZE-1:0]              valid_q, valid_d, ready_q, ready_d;
    rob_entry_t [ROB_SIZE-1:0]        entry_q, entry_d;
    logic                             halted_q, halted_d;

    logic                             clear_q, clear_d;
    logic [DATA_W-1:0]                new_pc_q, new_pc_d;
    logic                             reg_valid_q, reg_valid_d;
    logic [DEST_W-1:0]                reg_dest_q, reg_dest_d;
    logic [DATA_W-1:0]                reg_value_q, reg_value_d;
    logic [ROB_WIDTH-1:0]             reg_id_q, reg_id_d;
    logic                             pred_valid_q, pred_valid_d;
    logic [DATA_W-1:0]                upd_iaddr_q, upd_iaddr_d;
    logic                             jump_result_q, jump_result_d;
    logic                             store_valid_q, store_valid_d;
    logic [ROB_WIDTH-1:0]             store_id_q, store_id_d;

    logic                             alloc_c, commit_c, mispredict_c;
    logic [ROB_WIDTH-1:0]             wb_idx_c;
    rob_entry_t                       head_entry_c;
    logic [ROB_SIZE-1:0][DATA_W-1:0]  entry_value_c;

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        valid_d       = valid_q;
        ready_d       = ready_q;
        entry_d       = entry_q;
        halted_d      = halted_q;
        clear_d       = 1'b0;
        new_pc_d      = '0;
        reg_valid_d   = 1'b0;
        reg_dest_d    = '0;
        reg_value_d   = '0;
        reg_id_d      = '0;
        pred_valid_d  = 1'b0;
        upd_iaddr_d   = '0;
        jump_result_d = 1'b0;
        store_valid_d = 1'b0;
        store_id_d    = '0;
        mispredict_c  = 1'b0;
        wb_idx_c      = '0;
        head_entry_c  = entry_q[head_q];

        alloc_c  = bus.addValid && !clear_q;
        commit_c = (count_q != '0) && valid_q[head_q] && ready_q[head_q] && !halted_q && !clear_q;

        // Writebacks only land on live entries; later channels overwrite earlier ones.
        if (!clear_q) begin
            for (int k = 0; k < WB_PORTS; k++) begin
                wb_idx_c = bus.wbRobIndex[k*ROB_WIDTH +: ROB_WIDTH];
                if (bus.wbValid[k] && valid_q[wb_idx_c]) begin
                    entry_d[wb_idx_c].value = bus.wbValue[k*DATA_W +: DATA_W];
                    ready_d[wb_idx_c]       = 1'b1;
                end
            end
        end

        if (commit_c) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + ROB_WIDTH'(1);
            case (head_entry_c.kind)
                ROB_REG: begin
                    reg_valid_d = 1'b1;
                    reg_dest_d  = head_entry_c.dest;
                    reg_value_d = head_entry_c.value;
                    reg_id_d    = head_q;
                end
                ROB_BRANCH: begin
                    pred_valid_d  = 1'b1;
                    upd_iaddr_d   = head_entry_c.instr_addr;
                    jump_result_d = head_entry_c.value[0];
                    mispredict_c  = head_entry_c.value[0] != head_entry_c.jump;
                end
                ROB_STORE: begin
                    store_valid_d = 1'b1;
                    store_id_d    = head_q;
                end
                ROB_HALT: halted_d = 1'b1;
                default: ;
            endcase
        end

        if (alloc_c) begin
            entry_d[tail_q] = '{kind:       rob_type_e'(bus.addType),
                                jump:       bus.addJump,
                                value:      bus.addValue,
                                dest:       bus.addDest,
                                miss_addr:  bus.addAddr,
                                instr_addr: bus.addInstrAddr};
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = bus.addReady;
            tail_d          = tail_q + ROB_WIDTH'(1);
        end

        count_d = count_q + CNT_W'(alloc_c) - CNT_W'(commit_c);

        // A wrong-way branch discards everything younger, including this cycle's allocation.
        if (mispredict_c) begin
            clear_d  = 1'b1;
            new_pc_d = head_entry_c.miss_addr;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            valid_d  = '0;
        end
    end

    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            valid_q       <= '0;
            ready_q       <= '0;
            entry_q       <= '0;
            halted_q      <= 1'b0;
            clear_q       <= 1'b0;
            new_pc_q      <= '0;
            reg_valid_q   <= 1'b0;
            reg_dest_q    <= '0;
            reg_value_q   <= '0;
            reg_id_q      <= '0;
            pred_valid_q  <= 1'b0;
            upd_iaddr_q   <= '0;
            jump_result_q <= 1'b0;
            store_valid_q <= 1'b0;
            store_id_q    <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            valid_q       <= valid_d;
            ready_q       <= ready_d;
            entry_q       <= entry_d;
            halted_q      <= halted_d;
            clear_q       <= clear_d;
            new_pc_q      <= new_pc_d;
            reg_valid_q   <= reg_valid_d;
            reg_dest_q    <= reg_dest_d;
            reg_value_q   <= reg_value_d;
            reg_id_q      <= reg_id_d;
            pred_valid_q  <= pred_valid_d;
            upd_iaddr_q   <= upd_iaddr_d;
            jump_result_q <= jump_result_d;
            store_valid_q <= store_valid_d;
            store_id_q    <= store_id_d;
        end
    end

    always_comb begin
        entry_value_c = '0;
        for (int i = 0; i < ROB_SIZE; i++) entry_value_c[i] = entry_q[i].value;
    end

    rob_operand_lookup #(.ROB_WIDTH(ROB_WIDTH), .ROB_SIZE(ROB_SIZE), .WB_PORTS(WB_PORTS)) u_rs1 (
        .dep(bus.rs1Dep), .entry_valid(valid_q), .entry_ready(ready_q), .entry_value(entry_value_c),
        .wb_valid(bus.wbValid), .wb_index(bus.wbRobIndex), .wb_value(bus.wbValue),
        .ready_c(bus.rs1Ready), .value_c(bus.rs1Value)
    );

    rob_operand_lookup #(.ROB_WIDTH(ROB_WIDTH), .ROB_SIZE(ROB_SIZE), .WB_PORTS(WB_PORTS)) u_rs2 (
        .dep(bus.rs2Dep), .entry_valid(valid_q), .entry_ready(ready_q), .entry_value(entry_value_c),
        .wb_valid(bus.wbValid), .wb_index(bus.wbRobIndex), .wb_value(bus.wbValue),
        .ready_c(bus.rs2Ready), .value_c(bus.rs2Value)
    );

    assign bus.clear            = clear_q;
    assign bus.newPc            = new_pc_q;
    assign bus.full             = count_q >= CNT_W'(ROB_SIZE - FULL_MARGIN);
    assign bus.next             = tail_q;
    assign bus.regUpdateValid   = reg_valid_q;
    assign bus.regUpdateDest    = reg_dest_q;
    assign bus.regValue         = reg_value_q;
    assign bus.regUpdateRobId   = reg_id_q;
    assign bus.predictUpdValid  = pred_valid_q;
    assign bus.updInstrAddr     = upd_iaddr_q;
    assign bus.jumpResult       = jump_result_q;
    assign bus.storeCommitValid = store_valid_q;
    assign bus.storeCommitRobId = store_id_q;
    assign bus.robBeginId       = head_q;
    assign bus.beginValid       = count_q != '0;
    assign bus.halted           = halted_q;

endmodule
